alu_core: RTL and testbench

- 8-bit registered ALU with carry-in/carry-out.
- Two modes: mode_select=0 selects arithmetic/shift; mode_select=1 selects bitwise logic. control_line picks one of 8 operations per mode.
- Leaf datapath block. All inputs are sampled on one clock edge, and the result and carry are registered, so both are visible one cycle later.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_comb.sv | 59 +++++
 rtl/alu_core.sv | 61 ++++++
 tb/tb_alu_core.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared width, mode and opcode constants
// for the registered 8-bit ALU.
package alu_pkg;

  localparam int WIDTH = 8;

  localparam logic MODE_ARITH = 1'b0;
  localparam logic MODE_LOGIC = 1'b1;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_INC  = 3'd2;
  localparam logic [2:0] OP_DEC  = 3'd3;
  localparam logic [2:0] OP_TCA  = 3'd4;
  localparam logic [2:0] OP_SHL  = 3'd5;
  localparam logic [2:0] OP_SHR  = 3'd6;
  localparam logic [2:0] OP_RSUB = 3'd7;

  localparam logic [2:0] OP_AND   = 3'd0;
  localparam logic [2:0] OP_OR    = 3'd1;
  localparam logic [2:0] OP_XOR   = 3'd2;
  localparam logic [2:0] OP_NAND  = 3'd3;
  localparam logic [2:0] OP_NOR   = 3'd4;
  localparam logic [2:0] OP_XNOR  = 3'd5;
  localparam logic [2:0] OP_NOTA  = 3'd6;
  localparam logic [2:0] OP_PASSB = 3'd7;

endpackage

// File: rtl/alu_comb.sv
// alu_comb: combinational operation decode; produces
// the next result and carry for the output register.
module alu_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = alu_pkg::WIDTH
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             c_in,
  input  logic [2:0]       control_line,
  input  logic             mode_select,
  output logic [WIDTH-1:0] next_out,
  output logic             next_cout
);

  logic [WIDTH:0] ax, bx, nax, nbx, cx, one, ones;
  logic [WIDTH:0] res;

  assign ax   = {1'b0, A};
  assign bx   = {1'b0, B};
  assign nax  = {1'b0, ~A};
  assign nbx  = {1'b0, ~B};
  assign cx   = {{WIDTH{1'b0}}, c_in};
  assign one  = {{WIDTH{1'b0}}, 1'b1};
  assign ones = {1'b0, {WIDTH{1'b1}}};

  // res packs {carry, result}; logic ops leave carry at 0
  always_comb begin
    res = '0;
    if (mode_select == MODE_ARITH) begin
      unique case (control_line)
        OP_ADD:  res = ax + bx + cx;
        OP_SUB:  res = ax + nbx + cx;
        OP_INC:  res = ax + one;
        OP_DEC:  res = ax + ones;
        OP_TCA:  res = ax + cx;
        OP_SHL:  res = {A, c_in};
        OP_SHR:  res = {A[0], c_in, A[WIDTH-1:1]};
        OP_RSUB: res = bx + nax + one;
      endcase
    end else begin
      unique case (control_line)
        OP_AND:   res = {1'b0, A & B};
        OP_OR:    res = {1'b0, A | B};
        OP_XOR:   res = {1'b0, A ^ B};
        OP_NAND:  res = {1'b0, ~(A & B)};
        OP_NOR:   res = {1'b0, ~(A | B)};
        OP_XNOR:  res = {1'b0, ~(A ^ B)};
        OP_NOTA:  res = {1'b0, ~A};
        OP_PASSB: res = {1'b0, B};
      endcase
    end
  end

  assign next_out  = res[WIDTH-1:0];
  assign next_cout = res[WIDTH];

endmodule

// File: rtl/alu_core.sv
// alu_core: registered ALU, one-cycle latency.
// ALU_FLAGS_EN adds registered zero/neg outputs.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = alu_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             c_in,
  input  logic [2:0]       control_line,
  input  logic             mode_select,
  output logic [WIDTH-1:0] out,
  output logic             c_out
`ifdef ALU_FLAGS_EN
  ,
  output logic             zero,
  output logic             neg
`endif
);

  logic [WIDTH-1:0] next_out;
  logic             next_cout;

  alu_comb #(
    .WIDTH(WIDTH)
  ) u_comb (
    .A           (A),
    .B           (B),
    .c_in        (c_in),
    .control_line(control_line),
    .mode_select (mode_select),
    .next_out    (next_out),
    .next_cout   (next_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out   <= '0;
      c_out <= 1'b0;
    end else begin
      out   <= next_out;
      c_out <= next_cout;
    end
  end

`ifdef ALU_FLAGS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero <= 1'b0;
      neg  <= 1'b0;
    end else begin
      zero <= ~|next_out;
      neg  <= next_out[WIDTH-1];
    end
  end
`endif

endmodule

// File: tb/tb_alu_core.sv
// tb_alu_core: directed and random checks of alu_core
// against an arithmetic reference model.
module tb_alu_core;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] a, b;
  logic       c_in;
  logic [2:0] ctl;
  logic       mode;
  logic [7:0] out;
  logic       c_out;
`ifdef ALU_FLAGS_EN
  logic       zero, neg;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  alu_core dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .A           (a),
    .B           (b),
    .c_in        (c_in),
    .control_line(ctl),
    .mode_select (mode),
    .out         (out),
    .c_out       (c_out)
`ifdef ALU_FLAGS_EN
    ,
    .zero        (zero),
    .neg         (neg)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [8:0] got,
                       input logic [8:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // {carry, result} from plain integer arithmetic
  function automatic logic [8:0] model(input int x, input int y,
                                       input int ci, input int op,
                                       input int md);
    int r;
    r = 0;
    if (md == 0) begin
      case (op)
        0: r = x + y + ci;
        1: r = x + (255 - y) + ci;
        2: r = x + 1;
        3: r = x + 255;
        4: r = x + ci;
        5: r = x * 2 + ci;
        6: r = (x % 2) * 256 + ci * 128 + x / 2;
        7: r = y + (255 - x) + 1;
        default: r = 0;
      endcase
    end else begin
      case (op)
        0: r = x & y;
        1: r = x | y;
        2: r = x ^ y;
        3: r = 255 - (x & y);
        4: r = 255 - (x | y);
        5: r = 255 - (x ^ y);
        6: r = 255 - x;
        7: r = y;
        default: r = 0;
      endcase
    end
    return 9'(r);
  endfunction

  task automatic run_op(input logic [7:0] ia, input logic [7:0] ib,
                        input logic ic, input logic [2:0] op,
                        input logic md);
    @(negedge clk);
    a = ia; b = ib; c_in = ic; ctl = op; mode = md;
    @(posedge clk);
    #1;
  endtask

  logic [8:0] arith_exp [8];
  logic [8:0] logic_exp [8];
  logic [8:0] prev, exp;

  initial begin
    arith_exp = '{9'h005, 9'h0FE, 9'h003, 9'h101,
                  9'h002, 9'h004, 9'h001, 9'h101};
    logic_exp = '{9'h002, 9'h003, 9'h001, 9'h0FD,
                  9'h0FC, 9'h0FE, 9'h0FD, 9'h003};

    rst_n = 1'b0;
    a = 8'd2; b = 8'd3; c_in = 1'b0; ctl = 3'd0; mode = 1'b0;
    #12;
    check("reset_state", {c_out, out}, 9'h000);
`ifdef ALU_FLAGS_EN
    check("reset_flags", {7'b0, zero, neg}, 9'h000);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("add_before_reset", {c_out, out}, 9'h005);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset", {c_out, out}, 9'h000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("first_after_release", {c_out, out}, 9'h005);

    for (int i = 0; i < 8; i++) begin
      run_op(8'd2, 8'd3, 1'b0, 3'(i), 1'b0);
      check($sformatf("arith_op%0d", i), {c_out, out}, arith_exp[i]);
    end
    for (int i = 0; i < 8; i++) begin
      run_op(8'd2, 8'd3, 1'b0, 3'(i), 1'b1);
      check($sformatf("logic_op%0d", i), {c_out, out}, logic_exp[i]);
    end

    run_op(8'hFF, 8'h01, 1'b1, 3'd0, 1'b0);
    check("add_carry", {c_out, out}, 9'h101);
    run_op(8'h05, 8'h05, 1'b1, 3'd1, 1'b0);
    check("sub_equal", {c_out, out}, 9'h100);
`ifdef ALU_FLAGS_EN
    check("sub_flags", {7'b0, zero, neg}, 9'h002);
`endif
    run_op(8'h00, 8'h00, 1'b0, 3'd3, 1'b0);
    check("dec_zero", {c_out, out}, 9'h0FF);
    run_op(8'h01, 8'h00, 1'b1, 3'd6, 1'b0);
    check("shr_cin", {c_out, out}, 9'h180);
    run_op(8'h00, 8'h00, 1'b0, 3'd4, 1'b1);
    check("nor_zero", {c_out, out}, 9'h0FF);
`ifdef ALU_FLAGS_EN
    check("nor_flags", {7'b0, zero, neg}, 9'h001);
`endif

    prev = {c_out, out};
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      a    = (i % 17 == 0) ? 8'hFF : 8'($urandom);
      b    = (i % 13 == 0) ? 8'h00 : 8'($urandom);
      c_in = 1'($urandom);
      ctl  = 3'($urandom);
      mode = 1'($urandom);
      exp  = model(int'(a), int'(b), int'(c_in), int'(ctl), int'(mode));
      #1;
      check("hold_until_edge", {c_out, out}, prev);
      @(posedge clk);
      #1;
      check($sformatf("rand_m%0d_op%0d", mode, ctl), {c_out, out}, exp);
`ifdef ALU_FLAGS_EN
      check("rand_flags", {7'b0, zero, neg},
            {7'b0, exp[7:0] == 8'h00, exp[7]});
`endif
      prev = exp;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
